// File: rtl/hex_display_writer_if.sv
// CPU store port and LED scan-block write port of hex_display_writer.
// master = CPU/bench side, slave = hex_display_writer.
interface hex_display_writer_if;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_in;
    logic        led_we;
    logic [15:0] led_addr;
    logic [15:0] led_in;
    logic        busy;
    logic        drop_err;

    modport master (
        output cpu_we, cpu_addr, cpu_in,
        input  led_we, led_addr, led_in, busy, drop_err
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_in,
        output led_we, led_addr, led_in, busy, drop_err
    );
endinterface

// File: rtl/hex_display_writer.sv
// Expands a 16-bit store to TRIG_ADDR into four 7-segment digit writes; forwards raw digit
// stores when idle. Optional leading-zero blanking under HEX_DISPLAY_WRITER_BLANK_EN.
module hex_display_writer #(
    parameter logic [9:0] TRIG_ADDR = 10'h3FB,
    parameter logic [9:0] BASE_ADDR = 10'h3FC
) (
    input  logic               clk,
    input  logic               rst_n,
    hex_display_writer_if.slave bus
);

    typedef enum logic {StIdle, StSeq} state_e;

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    state_e      r_state;
    logic [15:0] r_shift;
    logic [1:0]  r_digit;
    logic        r_pend_vld;
    logic [15:0] r_pend_val;
    logic        r_led_we;
    logic [9:0]  r_led_addr;
    logic [15:0] r_led_in;
    logic        r_busy;
    logic        r_drop_err;

    logic        w_trig;
    logic        w_direct;
    logic [9:0]  w_off;
    logic [3:0]  w_nib;
    logic [7:0]  w_seg;

    always_comb begin
        w_trig   = bus.cpu_we && (bus.cpu_addr[9:0] == TRIG_ADDR);
        w_off    = bus.cpu_addr[9:0] - BASE_ADDR;
        w_direct = bus.cpu_we && (bus.cpu_addr[9:0] >= BASE_ADDR) && (w_off < 10'd4);
        case (r_digit)
            2'd0:    w_nib = r_shift[3:0];
            2'd1:    w_nib = r_shift[7:4];
            2'd2:    w_nib = r_shift[11:8];
            default: w_nib = r_shift[15:12];
        endcase
`ifdef HEX_DISPLAY_WRITER_BLANK_EN
        // Blank when this and every higher nibble is zero; digit 0 always shows.
        if ((r_digit != 2'd0) && ((r_shift >> {r_digit, 2'b00}) == 16'h0000)) begin
            w_seg = 8'hFF;
        end else begin
            w_seg = enc(w_nib);
        end
`else
        w_seg = enc(w_nib);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= 16'h0000;
            r_digit    <= 2'd0;
            r_pend_vld <= 1'b0;
            r_pend_val <= 16'h0000;
            r_led_we   <= 1'b0;
            r_led_addr <= 10'h000;
            r_led_in   <= 16'h0000;
            r_busy     <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            r_led_we <= 1'b0;
            r_busy   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_trig) begin
                        r_shift <= bus.cpu_in;
                        r_digit <= 2'd0;
                        r_state <= StSeq;
                    end else if (w_direct) begin
                        r_led_we   <= 1'b1;
                        r_led_addr <= bus.cpu_addr[9:0];
                        r_led_in   <= bus.cpu_in;
                    end
                end
                StSeq: begin
                    r_led_we   <= 1'b1;
                    r_busy     <= 1'b1;
                    r_led_addr <= BASE_ADDR + {8'b0, r_digit};
                    r_led_in   <= {8'h00, w_seg};
                    if (w_direct) begin
                        r_drop_err <= 1'b1;
                    end
                    if (r_digit == 2'd3) begin
                        // A trigger arriving now is newer than any pending value.
                        if (w_trig || r_pend_vld) begin
                            r_shift    <= w_trig ? bus.cpu_in : r_pend_val;
                            r_pend_vld <= 1'b0;
                            r_digit    <= 2'd0;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_digit <= r_digit + 2'd1;
                        if (w_trig) begin
                            r_pend_vld <= 1'b1;
                            r_pend_val <= bus.cpu_in;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.led_we   = r_led_we;
    assign bus.led_addr = {6'b0, r_led_addr};
    assign bus.led_in   = r_led_in;
    assign bus.busy     = r_busy;
    assign bus.drop_err = r_drop_err;

endmodule

// File: tb/tb_hex_display_writer.sv
// Directed bench for hex_display_writer; expected leading-zero digits follow
// HEX_DISPLAY_WRITER_BLANK_EN.
module tb_hex_display_writer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef HEX_DISPLAY_WRITER_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    hex_display_writer_if bus ();

    hex_display_writer #(
        .TRIG_ADDR(10'h3FB),
        .BASE_ADDR(10'h3FC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_in   = d;
    endtask

    // Present one store across a single posedge; outputs of that edge are visible on return.
    task automatic cyc(input logic we, input logic [15:0] a, input logic [15:0] d);
        drive(we, a, d);
        @(negedge clk);
        drive(1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic chk_ctl(input string tag, input logic we, input logic bsy, input logic drp);
        checks++;
        assert ({bus.led_we, bus.busy, bus.drop_err} === {we, bsy, drp}) else begin
            errors++;
            $error("FAIL %s: we/busy/drop observed=%b expected=%b", tag,
                   {bus.led_we, bus.busy, bus.drop_err}, {we, bsy, drp});
        end
    endtask

    task automatic chk_bus(input string tag, input logic [15:0] addr, input logic [15:0] din);
        checks++;
        assert ({bus.led_addr, bus.led_in} === {addr, din}) else begin
            errors++;
            $error("FAIL %s: addr/data observed=%h/%h expected=%h/%h", tag,
                   bus.led_addr, bus.led_in, addr, din);
        end
    endtask

    task automatic chk_dig(input string tag, input int d, input logic [7:0] seg, input logic drp);
        chk_ctl(tag, 1'b1, 1'b1, drp);
        chk_bus(tag, 16'h03FC + 16'(d), {8'h00, seg});
    endtask

    task automatic trig_seq(input string tag, input logic [15:0] val, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_seg [4];
        exp_seg = '{e0, e1, e2, e3};
        cyc(1'b1, 16'h03FB, val);
        chk_ctl({tag, "_T"}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_dig($sformatf("%s_d%0d", tag, i), i, exp_seg[i], 1'b0);
        end
        @(negedge clk);
        chk_ctl({tag, "_end"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_bus("reset", 16'h0000, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_ctl($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
        end
        chk_bus("idle", 16'h0000, 16'h0000);

        trig_seq("h12AF", 16'h12AF, 8'h8E, 8'h88, 8'hA4, 8'hF9);

        // Pending slot: 5555 overwritten by BEEF, which follows with no gap.
        cyc(1'b1, 16'h03FB, 16'h0001);
        chk_ctl("pend_T", 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 16'h0000);
        chk_dig("pend_a0", 0, 8'hF9, 1'b0);
        cyc(1'b1, 16'h03FB, 16'h5555);
        chk_dig("pend_a1", 1, LZ, 1'b0);
        cyc(1'b1, 16'h03FB, 16'hBEEF);
        chk_dig("pend_a2", 2, LZ, 1'b0);
        @(negedge clk);
        chk_dig("pend_a3", 3, LZ, 1'b0);
        @(negedge clk); chk_dig("pend_b0", 0, 8'h8E, 1'b0);
        @(negedge clk); chk_dig("pend_b1", 1, 8'h86, 1'b0);
        @(negedge clk); chk_dig("pend_b2", 2, 8'h86, 1'b0);
        @(negedge clk); chk_dig("pend_b3", 3, 8'h83, 1'b0);
        @(negedge clk); chk_ctl("pend_end", 1'b0, 1'b0, 1'b0);

        // Trigger coincident with the last digit write.
        cyc(1'b1, 16'h03FB, 16'h0007);
        chk_ctl("b2b_T", 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_dig("b2b_a0", 0, 8'hF8, 1'b0);
        @(negedge clk); chk_dig("b2b_a1", 1, LZ, 1'b0);
        @(negedge clk); chk_dig("b2b_a2", 2, LZ, 1'b0);
        cyc(1'b1, 16'h03FB, 16'h00C0);
        chk_dig("b2b_a3", 3, LZ, 1'b0);
        @(negedge clk); chk_dig("b2b_b0", 0, 8'hC0, 1'b0);
        @(negedge clk); chk_dig("b2b_b1", 1, 8'hC6, 1'b0);
        @(negedge clk); chk_dig("b2b_b2", 2, LZ, 1'b0);
        @(negedge clk); chk_dig("b2b_b3", 3, LZ, 1'b0);
        @(negedge clk); chk_ctl("b2b_end", 1'b0, 1'b0, 1'b0);

        cyc(1'b1, 16'h03FE, 16'h0012);
        chk_ctl("direct", 1'b1, 1'b0, 1'b0);
        chk_bus("direct", 16'h03FE, 16'h0012);
        @(negedge clk);
        chk_ctl("direct_end", 1'b0, 1'b0, 1'b0);

        // Direct write while busy is dropped and flagged.
        cyc(1'b1, 16'h03FB, 16'h1234);
        chk_ctl("drop_T", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h03FE, 16'h0012);
        chk_dig("drop_d0", 0, 8'h99, 1'b1);
        @(negedge clk); chk_dig("drop_d1", 1, 8'hB0, 1'b1);
        @(negedge clk); chk_dig("drop_d2", 2, 8'hA4, 1'b1);
        @(negedge clk); chk_dig("drop_d3", 3, 8'hF9, 1'b1);
        @(negedge clk); chk_ctl("drop_end", 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk_ctl("drop_sticky", 1'b0, 1'b0, 1'b1);

        cyc(1'b1, 16'h0200, 16'hFFFF);
        chk_ctl("other_addr", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_ctl("other_addr2", 1'b0, 1'b0, 1'b1);

        rst_n = 1'b0;
        @(negedge clk);
        chk_ctl("rst_pulse", 1'b0, 1'b0, 1'b0);
        chk_bus("rst_pulse", 16'h0000, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk_ctl("rst_after", 1'b0, 1'b0, 1'b0);

        // Reset at the second digit aborts the sequence.
        cyc(1'b1, 16'h03FB, 16'hABCD);
        chk_ctl("abort_T", 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_dig("abort_d0", 0, 8'hA1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_ctl("abort_rst", 1'b0, 1'b0, 1'b0);
        chk_bus("abort_rst", 16'h0000, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_ctl($sformatf("abort_quiet%0d", i), 1'b0, 1'b0, 1'b0);
        end

        trig_seq("h0030", 16'h0030, 8'hC0, 8'hB0, LZ, LZ);
        trig_seq("h0000", 16'h0000, 8'hC0, LZ, LZ, LZ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
